div_unit: RTL and testbench
===========================

Name: div_unit

Overview:
- Multi-cycle radix-2 restoring divider: the responder side of the ALU divide handshake.
- The execute-stage ALU raises start with latched operands and stalls the pipeline until ready.
- Returns {remainder, quotient} for MIPS DIV/DIVU, to be written into HI/LO.
- Supports annulment when an exception flushes the divide in flight.

Parameters:
- WIDTH, 32, operand width; result is 2*WIDTH.

Ports:
- clk  input  1  clock, rising edge
- rst  input  1  reset, synchronous, active-high
- signed_div  input  1  1 = DIV (two's complement), 0 = DIVU
- opdata1  input  WIDTH  dividend (rs)
- opdata2  input  WIDTH  divisor (rt)
- start  input  1  divide request, held high by the ALU until ready is seen
- annul  input  1  abort the current operation (exception flush)
- result  output  2*WIDTH  {remainder[63:32] -> HI, quotient[31:0] -> LO}
- ready  output  1  result valid

Behaviour:
- Reset: rst high at a clock edge sets state IDLE, ready=0, result=0, iteration counter=0 and working registers=0. rst overrides annul and start, including mid-operation.
- States: IDLE, CALC, DONE.
- Priority at every edge: rst > annul > normal transitions.
- IDLE, start=1 sampled at edge E0:
  - If opdata2==0: go to DONE, result=64'h0, ready=1 after E0. Divide-by-zero is decided, not undefined.
  - Else: latch |opdata1| and |opdata2| when signed_div=1 (raw values when 0). Latch the sign bits and signed_div. Clear the partial remainder, set counter=0, go to CALC.
- Operands are sampled only at E0. Later changes on opdata1, opdata2 or signed_div are ignored.
- CALC, edges E1..E32, one quotient bit per edge:
  - Shift {rem, quo} left 1.
  - Compute trial = rem_shifted - divisor as a WIDTH+1 bit subtraction.
  - If trial is non-negative: rem = trial and the quotient LSB = 1; else the quotient LSB = 0.
  - Counter increments 0..31 and does not wrap.
- CALC, edge E33 (counter==WIDTH):
  - Sign-correct: negate the quotient if signed and the operand signs differ; negate the remainder if signed and the dividend was negative.
  - Load result and go to DONE; ready=1 from E33.
  - Fixed latency: ready rises 33 edges after start is sampled (1 edge for divide-by-zero).
- DONE:
  - ready=1 and result held stable while start=1.
  - The first edge with start=0 goes to IDLE with ready=0; result keeps its value until the next completion.
  - Remaining in DONE while start stays high means no spurious restart.
- annul=1 at any edge in CALC or DONE: go to IDLE next edge with ready=0; result is not updated. A start asserted in the same cycle as annul is ignored.
- Width rules:
  - Absolute value uses two's-complement negation, so |0x80000000| = 0x80000000 as unsigned, which is correct.
  - INT_MIN / -1 yields quotient 0x80000000, remainder 0; no trap.
- Remainder sign always equals the dividend sign, or is zero.
- ready is a registered output with no combinational path from any input.

Decomposition:
- Shared include defines2.vh: the state encodings DIV_IDLE, DIV_CALC and DIV_DONE (2 bits).
- Shared include defines2.vh: the DIV_RESULT_READY and DIV_RESULT_NOT_READY constants.
- No sub-module. The restoring iteration is a single shift/subtract datapath inside the block.
- Any abs/negate helper stays local to the block.

Test Plan:
- Unsigned 100/7 (signed_div=0), start held: ready rises exactly 33 edges after start is sampled, result=64'h0000_0002_0000_000E; after start drops, ready=0 next edge.
- Signed -7/2 (0xFFFFFFF9, 0x2): result = {0xFFFFFFFF, 0xFFFFFFFD}. Repeat 7/-2: result = {0x00000001, 0xFFFFFFFD}.
- Signed 0x80000000 / 0xFFFFFFFF: result = {0x00000000, 0x80000000}. Unsigned 0xFFFFFFFF/1: result = {0, 0xFFFFFFFF}.
- Divisor 0 (opdata1=5): ready=1 one edge after start, result=64'h0.
- Annul and operand changes:
  - Start 1000/3, assert annul for one cycle at E10: ready never rises and the state returns to IDLE.
  - A fresh start of 9/4 then completes after 33 edges with {1, 2}.
  - Changing opdata1/opdata2 during CALC has no effect.
- Reset and hold:
  - Assert rst at E20 mid-CALC: next cycle ready=0 and result=0; a subsequent 8/8 returns {0, 1}.
  - Holding start high in DONE for 5 cycles keeps ready=1 and result constant.

Source files
------------

// File: rtl/div_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module      : div_unit_pkg
// Description : Shared definitions for the multi-cycle divider: FSM state
//               encodings and the result-ready flag values.
// Revision    : 1.0 - initial release
// ============================================================================
package div_unit_pkg;

    // Divider FSM states, 2-bit encoding shared with the ALU side.
    typedef enum logic [1:0] {
        DIV_IDLE = 2'b00,
        DIV_CALC = 2'b01,
        DIV_DONE = 2'b10
    } div_state_t;

    localparam logic DIV_RESULT_READY     = 1'b1;
    localparam logic DIV_RESULT_NOT_READY = 1'b0;

endpackage : div_unit_pkg
`default_nettype wire

// File: rtl/div_unit.sv
`default_nettype none
// ============================================================================
// Module      : div_unit
// Description : Multi-cycle radix-2 restoring divider for MIPS DIV/DIVU.
//               The ALU holds start high with stable operands until ready is
//               seen; result = {remainder, quotient} for HI/LO.
// Ports       : clk, rst        - clock (rising edge), sync active-high reset
//               signed_div      - 1 = DIV (two's complement), 0 = DIVU
//               opdata1/opdata2 - dividend / divisor, sampled on start only
//               start           - divide request, held until ready
//               annul           - abort the operation in flight
//               result          - {remainder, quotient}, held until next done
//               ready           - result valid (registered)
// Revision    : 1.0 - initial release
// ============================================================================
module div_unit
    import div_unit_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 signed_div,
    input  logic [WIDTH-1:0]     opdata1,
    input  logic [WIDTH-1:0]     opdata2,
    input  logic                 start,
    input  logic                 annul,
    output logic [2*WIDTH-1:0]   result,
    output logic                 ready
);

    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] c_last_cnt = CNT_W'(WIDTH);

    div_state_t         r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic [WIDTH-1:0]   r_rem;      // partial remainder
    logic [WIDTH-1:0]   r_quo;      // dividend shifts out MSB-first, quotient shifts in
    logic [WIDTH-1:0]   r_div;      // divisor magnitude
    logic               r_neg_quo;
    logic               r_neg_rem;

    logic [WIDTH-1:0]   w_abs_a;
    logic [WIDTH-1:0]   w_abs_b;
    logic [WIDTH:0]     w_rem_sh;
    logic [WIDTH:0]     w_trial;

    // Two's-complement negation gives |INT_MIN| = INT_MIN, which is the
    // correct magnitude when read as unsigned.
    assign w_abs_a = (signed_div && opdata1[WIDTH-1]) ? (-opdata1) : opdata1;
    assign w_abs_b = (signed_div && opdata2[WIDTH-1]) ? (-opdata2) : opdata2;

    // The remainder stays below the divisor, so the shifted remainder fits in
    // WIDTH+1 bits and the trial's MSB is a valid sign bit.
    assign w_rem_sh = {r_rem, r_quo[WIDTH-1]};
    assign w_trial  = w_rem_sh - {1'b0, r_div};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= DIV_IDLE;
            r_cnt     <= '0;
            r_rem     <= '0;
            r_quo     <= '0;
            r_div     <= '0;
            r_neg_quo <= 1'b0;
            r_neg_rem <= 1'b0;
            result    <= '0;
            ready     <= DIV_RESULT_NOT_READY;
        end else if (annul) begin
            // Flush: drop the operation, keep the last completed result.
            r_state <= DIV_IDLE;
            ready   <= DIV_RESULT_NOT_READY;
        end else begin
            case (r_state)
                DIV_IDLE: begin
                    if (start) begin
                        if (opdata2 == '0) begin
                            result  <= '0;
                            ready   <= DIV_RESULT_READY;
                            r_state <= DIV_DONE;
                        end else begin
                            r_quo     <= w_abs_a;
                            r_div     <= w_abs_b;
                            r_rem     <= '0;
                            r_cnt     <= '0;
                            r_neg_quo <= signed_div & (opdata1[WIDTH-1] ^ opdata2[WIDTH-1]);
                            r_neg_rem <= signed_div & opdata1[WIDTH-1];
                            r_state   <= DIV_CALC;
                        end
                    end
                end

                DIV_CALC: begin
                    if (r_cnt == c_last_cnt) begin
                        result[2*WIDTH-1:WIDTH] <= r_neg_rem ? (-r_rem) : r_rem;
                        result[WIDTH-1:0]       <= r_neg_quo ? (-r_quo) : r_quo;
                        ready                   <= DIV_RESULT_READY;
                        r_state                 <= DIV_DONE;
                    end else begin
                        if (!w_trial[WIDTH]) begin
                            r_rem <= w_trial[WIDTH-1:0];
                        end else begin
                            r_rem <= w_rem_sh[WIDTH-1:0];
                        end
                        r_quo <= {r_quo[WIDTH-2:0], ~w_trial[WIDTH]};
                        r_cnt <= r_cnt + 1'b1;
                    end
                end

                DIV_DONE: begin
                    // Stay here while start is held so the request is not
                    // mistaken for a new one.
                    if (!start) begin
                        ready   <= DIV_RESULT_NOT_READY;
                        r_state <= DIV_IDLE;
                    end
                end

                default: begin
                    r_state <= DIV_IDLE;
                    ready   <= DIV_RESULT_NOT_READY;
                end
            endcase
        end
    end

endmodule : div_unit
`default_nettype wire

// File: tb/tb_div_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_div_unit
// Description : Self-checking bench for div_unit. Stimulus pushes expected
//               results and latencies into queues; a monitor pops and compares
//               whenever ready rises.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_div_unit;

    logic        clk;
    logic        rst;
    logic        signed_div;
    logic [31:0] opdata1;
    logic [31:0] opdata2;
    logic        start;
    logic        annul;
    logic [63:0] result;
    logic        ready;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int start_cyc = 0;
    logic prev_ready = 1'b0;

    logic [63:0] exp_q[$];
    int          lat_q[$];

    div_unit #(.WIDTH(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .signed_div (signed_div),
        .opdata1    (opdata1),
        .opdata2    (opdata2),
        .start      (start),
        .annul      (annul),
        .result     (result),
        .ready      (ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc = cyc + 1;

    // Monitor: latency counts clock edges from the one sampling start up to
    // and including the edge that raises ready.
    always @(negedge clk) begin
        if (ready && !prev_ready) begin
            if (exp_q.size() == 0) begin
                checks = checks + 1;
                errors = errors + 1;
                $display("FAIL unexpected_ready: ready=1 result=%h with nothing expected", result);
            end else begin
                logic [63:0] e;
                int          l;
                e = exp_q.pop_front();
                l = lat_q.pop_front();
                checks = checks + 1;
                if (result !== e) begin
                    errors = errors + 1;
                    $display("FAIL result: got %h expected %h", result, e);
                end
                checks = checks + 1;
                if ((cyc - start_cyc) != l) begin
                    errors = errors + 1;
                    $display("FAIL latency: got %0d edges expected %0d", cyc - start_cyc, l);
                end
            end
        end
        prev_ready = ready;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            errors = errors + 1;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic run_div(input logic [31:0] a, input logic [31:0] b, input logic sg,
                           input logic [63:0] exp, input int lat, input int hold,
                           input bit perturb);
        int n;
        @(negedge clk);
        opdata1 = a; opdata2 = b; signed_div = sg; start = 1'b1;
        exp_q.push_back(exp);
        lat_q.push_back(lat);
        start_cyc = cyc;
        n = 0;
        while (!ready && n < 100) begin
            @(negedge clk);
            n++;
            if (perturb && n == 5) begin
                opdata1 = 32'hFFFF_FFF0; opdata2 = 32'h3; signed_div = ~sg;
            end
        end
        check("ready_timeout", {63'd0, ready}, 64'd1);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check("hold_ready", {63'd0, ready}, 64'd1);
            check("hold_result", result, exp);
        end
        start = 1'b0;
        @(negedge clk);
        check("ready_drop", {63'd0, ready}, 64'd0);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; annul = 1'b0; signed_div = 1'b0;
        opdata1 = '0; opdata2 = '0;
        repeat (3) @(negedge clk);
        check("reset_ready", {63'd0, ready}, 64'd0);
        check("reset_result", result, 64'h0);
        rst = 1'b0;

        run_div(32'd100, 32'd7, 1'b0, 64'h0000_0002_0000_000E, 34, 5, 1'b0);
        run_div(32'hFFFF_FFF9, 32'h2, 1'b1, {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 34, 0, 1'b0);
        run_div(32'h7, 32'hFFFF_FFFE, 1'b1, {32'h0000_0001, 32'hFFFF_FFFD}, 34, 0, 1'b0);
        run_div(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, {32'h0, 32'h8000_0000}, 34, 0, 1'b0);
        run_div(32'hFFFF_FFFF, 32'h1, 1'b0, {32'h0, 32'hFFFF_FFFF}, 34, 0, 1'b0);
        run_div(32'd5, 32'd0, 1'b0, 64'h0, 1, 2, 1'b0);

        // Annul sampled at E10 of a 1000/3 divide; start dropped with it.
        @(negedge clk);
        opdata1 = 32'd1000; opdata2 = 32'd3; signed_div = 1'b0; start = 1'b1;
        repeat (10) @(negedge clk);
        annul = 1'b1; start = 1'b0;
        @(negedge clk);
        annul = 1'b0;
        check("annul_ready", {63'd0, ready}, 64'd0);
        repeat (40) @(negedge clk);
        check("annul_no_ready", {63'd0, ready}, 64'd0);
        check("annul_result_kept", result, 64'h0);

        // Operands disturbed mid-calculation must not matter.
        run_div(32'd9, 32'd4, 1'b0, {32'd1, 32'd2}, 34, 0, 1'b1);

        // Reset sampled at E20 of a 1000/3 divide.
        @(negedge clk);
        opdata1 = 32'd1000; opdata2 = 32'd3; signed_div = 1'b0; start = 1'b1;
        repeat (20) @(negedge clk);
        rst = 1'b1; start = 1'b0;
        @(negedge clk);
        check("rst_mid_ready", {63'd0, ready}, 64'd0);
        check("rst_mid_result", result, 64'h0);
        rst = 1'b0;

        run_div(32'd8, 32'd8, 1'b0, {32'd0, 32'd1}, 34, 0, 1'b0);

        repeat (3) @(negedge clk);
        checks = checks + 1;
        if (exp_q.size() != 0) begin
            errors = errors + 1;
            $display("FAIL leftover_expected: got %0d pending expected 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_div_unit
`default_nettype wire
